// File: rtl/rpn_alu_datapath.sv
// RPN calculator datapath: operand/opcode capture, registered ALU with NZCV flags, display mux.
// Optional: define RPN_DP_SAT_EN to saturate signed add/sub overflow instead of wrapping.
module rpn_alu_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_op_a,
  input  logic             load_op_b,
  input  logic             load_op_code,
  input  logic             update_res,
  input  logic             to_display_sel,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             result_valid,
  output logic [WIDTH-1:0] display_value
);

  logic [WIDTH-1:0] r_op_a, r_op_b, r_result, r_display;
  logic [1:0]       r_opcode;
  logic [3:0]       r_flags;
  logic             r_valid, r_pending;

  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_raw, w_res;
  logic             w_c, w_v;

  always_comb begin
    w_sum  = {1'b0, r_op_a} + {1'b0, r_op_b};
    w_diff = {1'b0, r_op_a} - {1'b0, r_op_b};
    w_raw  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (r_opcode)
      2'b00: begin
        w_raw = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];  // no borrow means A >= B
        w_v   = (r_op_a[WIDTH-1] != r_op_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_op_a[WIDTH-1]);
      end
      2'b01: begin
        w_raw = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_op_a[WIDTH-1]);
      end
      2'b10: w_raw = r_op_a | r_op_b;
      default: w_raw = r_op_a & r_op_b;
    endcase
`ifdef RPN_DP_SAT_EN
    // Overflow direction follows A's sign for both add and sub.
    if (w_v)
      w_res = r_op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      w_res = w_raw;
`else
    w_res = w_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_opcode  <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_valid   <= 1'b0;
      r_pending <= 1'b0;
      r_display <= '0;
    end else begin
      if (load_op_a)    r_op_a   <= data_in;
      if (load_op_b)    r_op_b   <= data_in;
      if (load_op_code) r_opcode <= data_in[1:0];
      r_pending <= load_op_code | update_res;
      if (r_pending) begin
        r_result <= w_res;
        r_flags  <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
        r_valid  <= 1'b1;
      end
      // An operand change invalidates, even on a commit edge.
      if (load_op_a || load_op_b) r_valid <= 1'b0;
      r_display <= to_display_sel ? r_result : data_in;
    end
  end

  assign op_a          = r_op_a;
  assign op_b          = r_op_b;
  assign result        = r_result;
  assign flags         = r_flags;
  assign result_valid  = r_valid;
  assign display_value = r_display;

endmodule

// File: tb/tb_rpn_alu_datapath.sv
// Scoreboard bench for rpn_alu_datapath; honours RPN_DP_SAT_EN when defined.
module tb_rpn_alu_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        load_op_a = 0, load_op_b = 0, load_op_code = 0, update_res = 0, to_display_sel = 0;
  logic [15:0] op_a, op_b, result, display_value;
  logic [3:0]  flags;
  logic        result_valid;

  int errs = 0, checks = 0;

  logic [15:0] m_a = '0, m_b = '0, m_res = '0, m_disp = '0;
  logic [1:0]  m_op = '0;
  logic [3:0]  m_flags = '0;
  logic        m_valid = 0, m_pend = 0;
  logic [19:0] sb_q[$];

  rpn_alu_datapath #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .load_op_a(load_op_a), .load_op_b(load_op_b), .load_op_code(load_op_code),
    .update_res(update_res), .to_display_sel(to_display_sel),
    .op_a(op_a), .op_b(op_b), .result(result), .flags(flags),
    .result_valid(result_valid), .display_value(display_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference ALU in signed/unsigned integer arithmetic; returns {result, N,Z,C,V}.
  function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int unsigned ua, ub;
    int sa, sb, sr;
    logic [15:0] r;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    sr = 0; c = 0; v = 0;
    case (op)
      2'd0: begin sr = sa - sb; r = 16'(ua - ub); c = (ua >= ub); v = (sr > 32767) || (sr < -32768); end
      2'd1: begin sr = sa + sb; r = 16'(ua + ub); c = ((ua + ub) > 65535); v = (sr > 32767) || (sr < -32768); end
      2'd2: r = a | b;
      default: r = a & b;
    endcase
`ifdef RPN_DP_SAT_EN
    if (v) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, r[15], (r == 16'h0000), c, v};
  endfunction

  // One clock: update the model with what the DUT saw at the edge, then compare.
  task automatic step();
    logic pend, la, lb, lc, ur;
    logic [15:0] din, disp_exp;
    logic [19:0] e;
    pend = m_pend; la = load_op_a; lb = load_op_b; lc = load_op_code; ur = update_res;
    din = data_in;
    disp_exp = to_display_sel ? m_res : data_in;
    @(posedge clk); #1;
    if (reset) begin
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flags = '0;
      m_valid = 0; m_pend = 0; m_disp = '0;
      sb_q.delete();
    end else begin
      if (pend) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb_q.pop_front();
          m_res = e[19:4]; m_flags = e[3:0]; m_valid = 1;
          chk("result", {16'h0, result}, {16'h0, m_res});
          chk("flags", {28'h0, flags}, {28'h0, m_flags});
        end
      end
      if (la || lb) m_valid = 0;
      if (la) m_a = din;
      if (lb) m_b = din;
      if (lc) m_op = din[1:0];
      m_pend = lc | ur;
      if (m_pend) sb_q.push_back(ref_alu(m_a, m_b, m_op));
      m_disp = disp_exp;
    end
    chk("op_a", {16'h0, op_a}, {16'h0, m_a});
    chk("op_b", {16'h0, op_b}, {16'h0, m_b});
    chk("valid", {31'h0, result_valid}, {31'h0, m_valid});
    chk("display", {16'h0, display_value}, {16'h0, m_disp});
  endtask

  // Drive one strobe pattern for a single cycle.
  task automatic drv(input logic [15:0] d, input logic la, input logic lb, input logic lc, input logic ur);
    data_in = d; load_op_a = la; load_op_b = lb; load_op_code = lc; update_res = ur;
    step();
    load_op_a = 0; load_op_b = 0; load_op_code = 0; update_res = 0;
  endtask

  task automatic compute(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    drv(a, 1, 0, 0, 0);
    drv(b, 0, 1, 0, 0);
    drv({14'h0, op}, 0, 0, 1, 0);
    step();
  endtask

  initial begin
    reset = 1; step(); step();
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    reset = 0;

    drv(16'h0012, 1, 0, 0, 0);
    drv(16'h0034, 0, 1, 0, 0);
    chk("a_loaded", {16'h0, op_a}, 32'h0012);
    drv(16'h0001, 0, 0, 1, 0);
    step();
    chk("add_46", {16'h0, result}, 32'h0046);

    compute(16'h7FFF, 16'h0001, 2'd1);
`ifdef RPN_DP_SAT_EN
    chk("sat_pos", {16'h0, result}, 32'h7FFF);
    chk("sat_flags", {28'h0, flags}, 32'h1);
`else
    chk("ovf_wrap", {16'h0, result}, 32'h8000);
    chk("ovf_flags", {28'h0, flags}, 32'h9);
`endif
    compute(16'h0005, 16'h0005, 2'd0);
    chk("sub_zero_flags", {28'h0, flags}, 32'h6);
    drv(16'h0006, 0, 1, 0, 0);
    drv(16'h0000, 0, 0, 0, 1);
    step();
    chk("sub_neg", {16'h0, result}, 32'hFFFF);
    chk("sub_neg_flags", {28'h0, flags}, 32'h8);

    compute(16'h00F0, 16'h0F0F, 2'd2);
    compute(16'h00F0, 16'h0F3C, 2'd3);
    compute(16'h8000, 16'h0001, 2'd0);

    // Operand load on the commit edge: result updates, valid stays low.
    drv(16'h0001, 0, 0, 1, 0);
    drv(16'h1234, 1, 0, 0, 0);
    chk("clear_wins", {31'h0, result_valid}, 32'h0);

    // Simultaneous strobes and back-to-back re-arm.
    drv(16'h0001, 1, 1, 1, 0);
    drv(16'h0000, 0, 0, 0, 1);
    step();

    to_display_sel = 1; drv(16'hABCD, 0, 0, 0, 0);
    to_display_sel = 0; drv(16'h5A5A, 0, 0, 0, 0);
    to_display_sel = 1; step();
    to_display_sel = 0;

    for (int i = 0; i < 24; i++)
      compute(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));

    // Reset the cycle after load_op_code kills the pending commit.
    drv(16'h0001, 0, 0, 1, 0);
    reset = 1; step();
    reset = 0; step();
    chk("rst_mid_result", {16'h0, result}, 32'h0);
    chk("rst_mid_valid", {31'h0, result_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
